// File: rtl/axis_s_word_unpacker_pkg.sv
// ---------------------------------------------------------------------------
// axis_s_word_unpacker_pkg
//   Shared definitions for the AXI-Stream ingress word unpacker:
//   - conv_mode_t      : external-to-internal precision conversion mode
//   - default widths   : top-level defaults for beat, external and internal words
//   - lane_count()     : number of external lanes carried in one beat
//   - conv_ext2int_p() : width-parametrised lane conversion
// ---------------------------------------------------------------------------
package axis_s_word_unpacker_pkg;

    typedef enum logic {
        CONV_FRAC_PAD = 1'b0,   // append zero fractional LSBs
        CONV_SIGN_EXT = 1'b1    // sign-extend to the left, integer-aligned
    } conv_mode_t;

    localparam int C_S_TDATA_WDT       = 32;
    localparam int C_EXT_DATA_WORD_WDT = 16;
    localparam int C_ARITH_WORD_LEN    = 24;

    // Widest word the conversion helper handles.
    localparam int C_CONV_MAX_WDT = 64;

    function automatic int lane_count(input int tdata_wdt, input int ext_wdt);
        return tdata_wdt / ext_wdt;
    endfunction

    // Converts the low ext_wdt bits of data into an int_wdt-bit word.
    // Operates on a fixed 64-bit container so callers of any width up to
    // C_CONV_MAX_WDT can share it; callers cast the result to their width.
    function automatic logic [C_CONV_MAX_WDT-1:0] conv_ext2int_p(
        input logic [C_CONV_MAX_WDT-1:0] data,
        input conv_mode_t                mode,
        input int                        ext_wdt,
        input int                        int_wdt
    );
        logic [C_CONV_MAX_WDT-1:0] ext_mask;
        logic [C_CONV_MAX_WDT-1:0] int_mask;
        logic [C_CONV_MAX_WDT-1:0] lane;
        logic [C_CONV_MAX_WDT-1:0] res;
        ext_mask = (ext_wdt >= C_CONV_MAX_WDT) ? '1 : ((64'd1 << ext_wdt) - 64'd1);
        int_mask = (int_wdt >= C_CONV_MAX_WDT) ? '1 : ((64'd1 << int_wdt) - 64'd1);
        lane     = data & ext_mask;
        if (int_wdt <= ext_wdt) begin
            res = lane;
        end else if (mode == CONV_FRAC_PAD) begin
            res = lane << (int_wdt - ext_wdt);
        end else if (((lane >> (ext_wdt - 1)) & 64'd1) != 64'd0) begin
            res = lane | ~ext_mask;
        end else begin
            res = lane;
        end
        return res & int_mask;
    endfunction

endpackage

// File: rtl/axis_s_word_unpacker.sv
// ---------------------------------------------------------------------------
// axis_s_word_unpacker
//   AXI-Stream slave ingress stage. Each accepted beat is split into
//   C_TDATA_WDT/C_EXT_WORD_WDT lanes; lanes with every byte kept are emitted
//   one per cycle in ascending lane order, converted to internal precision.
//   Partial lanes are dropped and flagged. Per-packet word counts are
//   reported on pkt_done/pkt_len.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   s_tdata/tkeep/tlast    incoming beat, byte qualifiers, packet end
//   s_tvalid/s_tready      slave handshake
//   m_data/m_last          converted word, last word of packet
//   m_valid/m_ready        master handshake
//   pkt_done/pkt_len       one-cycle pulse with saturating packet length
//   err_flags              sticky: [0] partial lane, [1] TLAST with no full lane
// ---------------------------------------------------------------------------
module axis_s_word_unpacker
    import axis_s_word_unpacker_pkg::*;
#(
    parameter int         C_TDATA_WDT    = C_S_TDATA_WDT,
    parameter int         C_EXT_WORD_WDT = C_EXT_DATA_WORD_WDT,
    parameter int         C_INT_WORD_WDT = C_ARITH_WORD_LEN,
    parameter conv_mode_t C_CONV_MODE    = CONV_FRAC_PAD,
    parameter int         C_CNT_WDT      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [C_TDATA_WDT-1:0]    s_tdata,
    input  logic [C_TDATA_WDT/8-1:0]  s_tkeep,
    input  logic                      s_tlast,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    output logic [C_INT_WORD_WDT-1:0] m_data,
    output logic                      m_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      pkt_done,
    output logic [C_CNT_WDT-1:0]      pkt_len,
    output logic [1:0]                err_flags
);

    localparam int N_LANES    = lane_count(C_TDATA_WDT, C_EXT_WORD_WDT);
    localparam int LANE_BYTES = C_EXT_WORD_WDT / 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    localparam logic [N_LANES-1:0]   LANE_ONE = N_LANES'(1);
    localparam logic [C_CNT_WDT-1:0] CNT_ONE  = C_CNT_WDT'(1);
    localparam logic [C_CNT_WDT-1:0] CNT_MAX  = '1;

    logic [0:0]             state_q,     state_d;
    logic [C_TDATA_WDT-1:0] hold_data_q, hold_data_d;
    logic                   hold_last_q, hold_last_d;
    logic [N_LANES-1:0]     mask_q,      mask_d;
    logic [C_CNT_WDT-1:0]   cnt_q,       cnt_d;
    logic [C_CNT_WDT-1:0]   pkt_len_q,   pkt_len_d;
    logic                   pkt_done_q,  pkt_done_d;
    logic [1:0]             err_q,       err_d;
    // Holds s_tready low until the first clock after reset release.
    logic                   rdy_en_q;

    logic [N_LANES-1:0]        beat_full;
    logic [N_LANES-1:0]        beat_partial;
    logic [C_INT_WORD_WDT-1:0] lane_conv [N_LANES];

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            logic [LANE_BYTES-1:0] keep_lane;
            assign keep_lane         = s_tkeep[gi*LANE_BYTES +: LANE_BYTES];
            assign beat_full[gi]     = &keep_lane;
            assign beat_partial[gi]  = (|keep_lane) && !(&keep_lane);
            assign lane_conv[gi]     = C_INT_WORD_WDT'(conv_ext2int_p(
                64'(hold_data_q[gi*C_EXT_WORD_WDT +: C_EXT_WORD_WDT]),
                C_CONV_MODE, C_EXT_WORD_WDT, C_INT_WORD_WDT));
        end
    endgenerate

    logic [N_LANES-1:0]        lane_sel;
    logic                      last_lane;
    logic                      m_hs;
    logic                      s_hs;
    logic                      s_tready_int;
    logic [C_INT_WORD_WDT-1:0] m_data_sel;
    logic [C_CNT_WDT-1:0]      cnt_inc;

    // Isolate the lowest remaining lane as a one-hot select.
    assign lane_sel  = mask_q & (~mask_q + LANE_ONE);
    // Remaining mask only ever holds full lanes, so the current lane is the
    // highest full lane exactly when it is the only one left.
    assign last_lane = (mask_q == lane_sel) && (mask_q != '0);

    assign m_valid      = (state_q == ST_EMIT);
    assign m_last       = m_valid && hold_last_q && last_lane;
    assign m_hs         = m_valid && m_ready;
    // Accept a new beat while idle, or in the same cycle the final lane of
    // the held beat leaves, so back-to-back beats flow without a bubble.
    assign s_tready_int = rdy_en_q && ((state_q == ST_IDLE) || (m_ready && last_lane));
    assign s_hs         = s_tvalid && s_tready_int;
    assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        m_data_sel = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (lane_sel[k]) begin
                m_data_sel = m_data_sel | lane_conv[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        pkt_len_d   = pkt_len_q;
        pkt_done_d  = 1'b0;
        err_d       = err_q;

        if (m_hs) begin
            mask_d = mask_q & ~lane_sel;
            cnt_d  = cnt_inc;
            if (m_last) begin
                pkt_len_d  = cnt_inc;
                pkt_done_d = 1'b1;
                cnt_d      = '0;
            end
            if (last_lane) begin
                state_d = ST_IDLE;
            end
        end

        if (s_hs) begin
            if (|beat_partial) begin
                err_d[0] = 1'b1;
            end
            if (|beat_full) begin
                state_d     = ST_EMIT;
                hold_data_d = s_tdata;
                hold_last_d = s_tlast;
                mask_d      = beat_full;
            end else if (s_tlast) begin
                err_d[1] = 1'b1;
                // If an m_last handshake already claimed this cycle's pulse,
                // that packet's report takes precedence over the empty one.
                if (!pkt_done_d) begin
                    pkt_len_d  = cnt_d;
                    pkt_done_d = 1'b1;
                    cnt_d      = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            mask_q      <= '0;
            cnt_q       <= '0;
            pkt_len_q   <= '0;
            pkt_done_q  <= 1'b0;
            err_q       <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            pkt_len_q   <= pkt_len_d;
            pkt_done_q  <= pkt_done_d;
            err_q       <= err_d;
            rdy_en_q    <= 1'b1;
        end
    end

    assign s_tready  = s_tready_int;
    assign m_data    = m_data_sel;
    assign pkt_done  = pkt_done_q;
    assign pkt_len   = pkt_len_q;
    assign err_flags = err_q;

endmodule

// File: tb/tb_axis_s_word_unpacker.sv
// ---------------------------------------------------------------------------
// tb_axis_s_word_unpacker
//   Two instances share one input stream: a FRAC_PAD unit with a 16-bit
//   counter and a SIGN_EXT unit with a 2-bit counter (saturates at 3).
//   A queue-based packet model predicts every output on every cycle; a few
//   literal expectations from hand calculation pin the model itself.
// ---------------------------------------------------------------------------
module tb_axis_s_word_unpacker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        m_ready;

    logic        f_s_tready, f_m_last, f_m_valid, f_pkt_done;
    logic [23:0] f_m_data;
    logic [15:0] f_pkt_len;
    logic [1:0]  f_err;

    logic        x_s_tready, x_m_last, x_m_valid, x_pkt_done;
    logic [23:0] x_m_data;
    logic [1:0]  x_pkt_len;
    logic [1:0]  x_err;

    always #5 clk = ~clk;

    axis_s_word_unpacker #(
        .C_TDATA_WDT(32), .C_EXT_WORD_WDT(16), .C_INT_WORD_WDT(24),
        .C_CONV_MODE(axis_s_word_unpacker_pkg::CONV_FRAC_PAD), .C_CNT_WDT(16)
    ) dut_frac (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(f_s_tready),
        .m_data(f_m_data), .m_last(f_m_last), .m_valid(f_m_valid), .m_ready(m_ready),
        .pkt_done(f_pkt_done), .pkt_len(f_pkt_len), .err_flags(f_err)
    );

    axis_s_word_unpacker #(
        .C_TDATA_WDT(32), .C_EXT_WORD_WDT(16), .C_INT_WORD_WDT(24),
        .C_CONV_MODE(axis_s_word_unpacker_pkg::CONV_SIGN_EXT), .C_CNT_WDT(2)
    ) dut_sext (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(x_s_tready),
        .m_data(x_m_data), .m_last(x_m_last), .m_valid(x_m_valid), .m_ready(m_ready),
        .pkt_done(x_pkt_done), .pkt_len(x_pkt_len), .err_flags(x_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [15:0] v;
        logic        last;
    } word_t;

    word_t       q[$];          // words accepted but not yet handed over
    int          cnt;           // words in current packet (unsaturated)
    logic        pend_done;     // pkt_done expected at next sample
    int          exp_len;
    logic [1:0]  exp_err;
    bit          ready_ok;      // first cycle after reset release has passed
    int          cyc = 0;
    int          stall_cyc = 0;

    logic [23:0] log_f[$];
    logic [23:0] log_x[$];
    logic        log_l[$];
    int          hs_cyc[$];
    int          len_f[$];
    int          len_x[$];
    bit          rdy_pat[$];

    function automatic logic [23:0] frac(input logic [15:0] v);
        return {v, 8'h00};
    endfunction

    function automatic logic [23:0] sext(input logic [15:0] v);
        return {{8{v[15]}}, v};
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(negedge clk) begin
        logic  exp_rdy;
        word_t w;
        int    hi;
        logic  part;
        logic  anyfull;
        cyc++;
        if (!rst_n) begin
            chk("rst_tready_f",  f_s_tready, 0);  chk("rst_tready_x",  x_s_tready, 0);
            chk("rst_mvalid_f",  f_m_valid, 0);   chk("rst_mvalid_x",  x_m_valid, 0);
            chk("rst_mlast_f",   f_m_last, 0);    chk("rst_mlast_x",   x_m_last, 0);
            chk("rst_mdata_f",   f_m_data, 0);    chk("rst_mdata_x",   x_m_data, 0);
            chk("rst_pdone_f",   f_pkt_done, 0);  chk("rst_pdone_x",   x_pkt_done, 0);
            chk("rst_plen_f",    f_pkt_len, 0);   chk("rst_plen_x",    x_pkt_len, 0);
            chk("rst_err_f",     f_err, 0);       chk("rst_err_x",     x_err, 0);
            q.delete();
            cnt = 0; pend_done = 0; exp_len = 0; exp_err = 2'b00; ready_ok = 0;
        end else begin
            exp_rdy = ready_ok && ((q.size() == 0) || (q.size() == 1 && m_ready));
            chk("tready_f", f_s_tready, exp_rdy);
            chk("tready_x", x_s_tready, exp_rdy);
            chk("mvalid_f", f_m_valid, q.size() > 0);
            chk("mvalid_x", x_m_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("mdata_f", f_m_data, frac(q[0].v));
                chk("mdata_x", x_m_data, sext(q[0].v));
                chk("mlast_f", f_m_last, q[0].last);
                chk("mlast_x", x_m_last, q[0].last);
                if (!m_ready) stall_cyc++;
            end
            chk("pdone_f", f_pkt_done, pend_done);
            chk("pdone_x", x_pkt_done, pend_done);
            chk("plen_f",  f_pkt_len, sat(exp_len, 65535));
            chk("plen_x",  x_pkt_len, sat(exp_len, 3));
            chk("err_f",   f_err, exp_err);
            chk("err_x",   x_err, exp_err);
            if (f_pkt_done) len_f.push_back(int'(f_pkt_len));
            if (x_pkt_done) len_x.push_back(int'(x_pkt_len));

            // events taking effect at the coming rising edge
            pend_done = 0;
            if (q.size() > 0 && m_ready) begin
                w = q.pop_front();
                log_f.push_back(f_m_data);
                log_x.push_back(x_m_data);
                log_l.push_back(f_m_last);
                hs_cyc.push_back(cyc);
                cnt++;
                if (w.last) begin
                    pend_done = 1; exp_len = cnt; cnt = 0;
                end
            end
            if (s_tvalid && exp_rdy) begin
                hi = -1; part = 0; anyfull = 0;
                for (int k = 0; k < 2; k++) begin
                    if (s_tkeep[2*k +: 2] == 2'b11) begin
                        hi = k; anyfull = 1;
                    end else if (s_tkeep[2*k +: 2] != 2'b00) begin
                        part = 1;
                    end
                end
                for (int k = 0; k < 2; k++) begin
                    if (s_tkeep[2*k +: 2] == 2'b11) begin
                        w.v    = s_tdata[16*k +: 16];
                        w.last = s_tlast && (k == hi);
                        q.push_back(w);
                    end
                end
                if (part) exp_err[0] = 1'b1;
                if (!anyfull && s_tlast) begin
                    exp_err[1] = 1'b1;
                    if (!pend_done) begin
                        pend_done = 1; exp_len = cnt; cnt = 0;
                    end
                end
            end
            ready_ok = 1;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_pat.size() > 0) m_ready = rdy_pat.pop_front();
            else                    m_ready = 1'b1;
        end
    end

    task automatic clear_logs();
        log_f.delete(); log_x.delete(); log_l.delete(); hs_cyc.delete();
        len_f.delete(); len_x.delete(); stall_cyc = 0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (f_s_tready) break;
            n++;
            if (n > 50) begin
                checks++; failures++;
                $display("FAIL beat_accept_timeout actual=no_tready required=tready data=%h", d);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (f_m_valid === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL drain_timeout actual=m_valid_stuck required=idle");
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1/2: full beat, both conversion modes
        clear_logs();
        send_beat(32'hBEEF_1234, 4'hF, 1'b1);
        drain();
        chk("t1_nwords",   log_f.size(), 2);
        chk("t1_w0_frac",  log_f[0], 24'h123400);
        chk("t1_w1_frac",  log_f[1], 24'hBEEF00);
        chk("t1_w0_last",  log_l[0], 0);
        chk("t1_w1_last",  log_l[1], 1);
        chk("t2_w0_sext",  log_x[0], 24'h001234);
        chk("t2_w1_sext",  log_x[1], 24'hFFBEEF);
        chk("t1_pkt_len",  len_f[0], 2);

        // 3: upper lane only, then partial lanes only
        clear_logs();
        send_beat(32'hA5A5_7F00, 4'hC, 1'b1);
        drain();
        chk("t3_nwords",   log_f.size(), 1);
        chk("t3_w0_frac",  log_f[0], 24'hA5A500);
        chk("t3_w0_sext",  log_x[0], 24'hFFA5A5);
        chk("t3_w0_last",  log_l[0], 1);
        chk("t3_pkt_len",  len_f[0], 1);
        clear_logs();
        send_beat(32'h1111_2222, 4'h6, 1'b0);
        drain();
        chk("t3_partial_nwords", log_f.size(), 0);
        chk("t3_partial_err",    f_err, 2'b01);

        // 4: three back-to-back full beats
        clear_logs();
        send_beat(32'h0002_0001, 4'hF, 1'b0);
        send_beat(32'h0004_0003, 4'hF, 1'b0);
        send_beat(32'h0006_0005, 4'hF, 1'b1);
        drain();
        chk("t4_nwords",   log_f.size(), 6);
        chk("t4_no_bubble", hs_cyc[5] - hs_cyc[0], 5);
        chk("t4_w5_frac",  log_f[5], 24'h000600);
        chk("t4_len_f",    len_f[0], 6);
        chk("t4_len_sat",  len_x[0], 3);

        // 5: back-pressure on the master side
        clear_logs();
        rdy_pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        send_beat(32'h8000_7FFF, 4'hF, 1'b1);
        drain();
        chk("t5_nwords",   log_f.size(), 2);
        chk("t5_stalled",  stall_cyc >= 2, 1);
        chk("t5_w0_sext",  log_x[0], 24'h007FFF);
        chk("t5_w1_sext",  log_x[1], 24'hFF8000);
        chk("t5_w1_frac",  log_f[1], 24'h800000);

        // 6: TLAST on an empty beat after 3 words
        clear_logs();
        send_beat(32'h0002_0001, 4'hF, 1'b0);
        send_beat(32'h0000_0003, 4'h3, 1'b0);
        send_beat(32'h0000_0000, 4'h0, 1'b1);
        drain();
        chk("t6_nwords",   log_f.size(), 3);
        chk("t6_len_f",    len_f[0], 3);
        chk("t6_len_x",    len_x[0], 3);
        chk("t6_err",      f_err, 2'b11);

        // reset asserted while a beat is held
        clear_logs();
        rdy_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        send_beat(32'hCAFE_F00D, 4'hF, 1'b1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_pat.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("t7_err_cleared", f_err, 2'b00);
        chk("t7_no_pkt_done", len_f.size(), 0);
        chk("t7_mvalid",      f_m_valid, 0);
        chk("t7_nwords",      log_f.size(), 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
